// File: rtl/wb_broadcast_arbiter_if.sv
// Result-broadcast arbiter bundle: flush, ALU/load producer handshakes, merged bus and stall counters.
// Latency: none of its own; it only groups the arbiter's non-clock signals.
// Backpressure: producers see *_ready; the merged broadcast bus has no ready.
interface wb_broadcast_arbiter_if #(
    parameter int ROB_W  = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic              flush;

    logic              alu_valid;
    logic              alu_ready;
    logic [ROB_W-1:0]  alu_rob_id;
    logic [DATA_W-1:0] alu_reg_data;
    logic              alu_npc_valid;
    logic              alu_npc_mispred;
    logic [ADDR_W-1:0] alu_npc;

    logic              ld_valid;
    logic              ld_ready;
    logic [ROB_W-1:0]  ld_rob_id;
    logic [DATA_W-1:0] ld_reg_data;

    logic              bus_valid;
    logic              bus_src_ld;
    logic [ROB_W-1:0]  bus_rob_id;
    logic [DATA_W-1:0] bus_reg_data;
    logic              bus_npc_valid;
    logic              bus_npc_mispred;
    logic [ADDR_W-1:0] bus_npc;

    logic [CNT_W-1:0]  alu_stall_cnt;
    logic [CNT_W-1:0]  ld_stall_cnt;

    // Arbiter side
    modport slave (
        input  flush,
        input  alu_valid, alu_rob_id, alu_reg_data, alu_npc_valid, alu_npc_mispred, alu_npc,
        output alu_ready,
        input  ld_valid, ld_rob_id, ld_reg_data,
        output ld_ready,
        output bus_valid, bus_src_ld, bus_rob_id, bus_reg_data,
        output bus_npc_valid, bus_npc_mispred, bus_npc,
        output alu_stall_cnt, ld_stall_cnt
    );

    // Producer / consumer side
    modport master (
        output flush,
        output alu_valid, alu_rob_id, alu_reg_data, alu_npc_valid, alu_npc_mispred, alu_npc,
        input  alu_ready,
        output ld_valid, ld_rob_id, ld_reg_data,
        input  ld_ready,
        input  bus_valid, bus_src_ld, bus_rob_id, bus_reg_data,
        input  bus_npc_valid, bus_npc_mispred, bus_npc,
        input  alu_stall_cnt, ld_stall_cnt
    );
endinterface

// File: rtl/wb_broadcast_arbiter.sv
// Merges ALU and load results onto one ROB/bypass broadcast bus via per-source FIFOs; WB_ARB_LD_PRIORITY_EN selects fixed load priority.
// Latency: one cycle from producer valid&ready to bus_valid (no same-cycle bypass).
// Backpressure: *_ready = ~full from registered pointers; the bus itself is never stalled.

// Small flushable FIFO with wrap-bit pointers; one write and one read per cycle.
module wb_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers/storage: flush drops everything including this cycle's push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_dat;
                wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module wb_broadcast_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int ROB_W      = 6,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_broadcast_arbiter_if.slave bif
);
    typedef struct packed {
        logic [ROB_W-1:0]  rob_id;
        logic [DATA_W-1:0] reg_data;
        logic              npc_valid;
        logic              npc_mispred;
        logic [ADDR_W-1:0] npc;
    } alu_ent_t;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_id;
        logic [DATA_W-1:0] reg_data;
    } ld_ent_t;

    alu_ent_t         alu_in, alu_head;
    ld_ent_t          ld_in, ld_head;
    logic             alu_full, alu_empty, ld_full, ld_empty;
    logic             alu_push, ld_push, alu_pop, ld_pop;
    logic             bus_vld, grant_ld;
    logic [CNT_W-1:0] alu_stall_cnt_q, alu_stall_cnt_d;
    logic [CNT_W-1:0] ld_stall_cnt_q, ld_stall_cnt_d;

    assign alu_in = '{rob_id: bif.alu_rob_id, reg_data: bif.alu_reg_data,
                      npc_valid: bif.alu_npc_valid, npc_mispred: bif.alu_npc_mispred,
                      npc: bif.alu_npc};
    assign ld_in  = '{rob_id: bif.ld_rob_id, reg_data: bif.ld_reg_data};

    assign bif.alu_ready = !alu_full;
    assign bif.ld_ready  = !ld_full;
    assign alu_push      = bif.alu_valid && !alu_full;
    assign ld_push       = bif.ld_valid && !ld_full;

    // Nothing is broadcast (or popped) in a flush or reset cycle.
    assign bus_vld = !rst && !bif.flush && (!alu_empty || !ld_empty);
    assign alu_pop = bus_vld && !grant_ld;
    assign ld_pop  = bus_vld && grant_ld;

    wb_arb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(alu_ent_t))) u_alu_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bif.flush),
        .push     (alu_push),
        .push_dat (alu_in),
        .pop      (alu_pop),
        .full     (alu_full),
        .empty    (alu_empty),
        .head_dat (alu_head)
    );

    wb_arb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ld_ent_t))) u_ld_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bif.flush),
        .push     (ld_push),
        .push_dat (ld_in),
        .pop      (ld_pop),
        .full     (ld_full),
        .empty    (ld_empty),
        .head_dat (ld_head)
    );

`ifdef WB_ARB_LD_PRIORITY_EN
    // Fixed priority: any buffered load beats the ALU.
    always_comb begin
        grant_ld = !ld_empty;
    end
`else
    logic last_grant_q, last_grant_d;

    // Round-robin on a tie: serve whichever source did not win last time.
    always_comb begin
        grant_ld = !ld_empty;
        if (!alu_empty && !ld_empty) begin
            grant_ld = !last_grant_q;
        end
        last_grant_d = bus_vld ? grant_ld : last_grant_q;
    end

    // Last granted source; flush leaves it untouched, reset favours the ALU next.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Drive the merged bus from the granted head; all-zero when idle, npc fields zero for loads.
    always_comb begin
        bif.bus_valid       = bus_vld;
        bif.bus_src_ld      = 1'b0;
        bif.bus_rob_id      = '0;
        bif.bus_reg_data    = '0;
        bif.bus_npc_valid   = 1'b0;
        bif.bus_npc_mispred = 1'b0;
        bif.bus_npc         = '0;
        if (bus_vld) begin
            if (grant_ld) begin
                bif.bus_src_ld   = 1'b1;
                bif.bus_rob_id   = ld_head.rob_id;
                bif.bus_reg_data = ld_head.reg_data;
            end else begin
                bif.bus_rob_id      = alu_head.rob_id;
                bif.bus_reg_data    = alu_head.reg_data;
                bif.bus_npc_valid   = alu_head.npc_valid;
                bif.bus_npc_mispred = alu_head.npc_mispred;
                bif.bus_npc         = alu_head.npc;
            end
        end
    end

    // Saturating stall counters: count offered-but-not-ready cycles, flush included.
    always_comb begin
        alu_stall_cnt_d = alu_stall_cnt_q;
        ld_stall_cnt_d  = ld_stall_cnt_q;
        if (bif.alu_valid && alu_full && (alu_stall_cnt_q != '1)) begin
            alu_stall_cnt_d = alu_stall_cnt_q + CNT_W'(1);
        end
        if (bif.ld_valid && ld_full && (ld_stall_cnt_q != '1)) begin
            ld_stall_cnt_d = ld_stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_stall_cnt_q <= '0;
            ld_stall_cnt_q  <= '0;
        end else begin
            alu_stall_cnt_q <= alu_stall_cnt_d;
            ld_stall_cnt_q  <= ld_stall_cnt_d;
        end
    end

    assign bif.alu_stall_cnt = alu_stall_cnt_q;
    assign bif.ld_stall_cnt  = ld_stall_cnt_q;
endmodule

// File: tb/tb_wb_broadcast_arbiter.sv
// Self-checking bench for wb_broadcast_arbiter: directed scenarios then random traffic against a queue model.
// Latency: checks every cycle on the falling edge, model advances on the rising edge.
// Backpressure: model ready is "queue holds fewer than FIFO_DEPTH entries".
module tb_wb_broadcast_arbiter;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int ROB_W   = 6;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_broadcast_arbiter_if #(.ROB_W(ROB_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bif ();

    wb_broadcast_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W),
        .ROB_W      (ROB_W),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    typedef struct {
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] data;
        logic              nv;
        logic              nm;
        logic [ADDR_W-1:0] npc;
    } ent_t;

    ent_t aq[$];
    ent_t lq[$];
    bit   m_last = 1'b1;
    int   m_acnt = 0;
    int   m_lcnt = 0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_grant_ld();
`ifdef WB_ARB_LD_PRIORITY_EN
        return lq.size() != 0;
`else
        if (lq.size() == 0) return 1'b0;
        if (aq.size() == 0) return 1'b1;
        return m_last == 1'b0;
`endif
    endfunction

    // One clock: compare outputs on the falling edge, then advance the model on the rising edge.
    task automatic step();
        bit   ev, gl, ar, lr;
        ent_t e;
        @(negedge clk);
        chk("alu_ready", bif.alu_ready, aq.size() < DEPTH);
        chk("ld_ready", bif.ld_ready, lq.size() < DEPTH);
        chk("alu_stall_cnt", bif.alu_stall_cnt, m_acnt);
        chk("ld_stall_cnt", bif.ld_stall_cnt, m_lcnt);
        if (!rst) begin
            ev = !bif.flush && (aq.size() + lq.size() > 0);
            gl = model_grant_ld();
            e  = '{rob: '0, data: '0, nv: 1'b0, nm: 1'b0, npc: '0};
            if (ev && gl) begin
                e.rob  = lq[0].rob;
                e.data = lq[0].data;
            end else if (ev) begin
                e = aq[0];
            end
            chk("bus_valid", bif.bus_valid, ev);
            chk("bus_src_ld", bif.bus_src_ld, ev && gl);
            chk("bus_rob_id", bif.bus_rob_id, e.rob);
            chk("bus_reg_data", bif.bus_reg_data, e.data);
            chk("bus_npc_valid", bif.bus_npc_valid, e.nv);
            chk("bus_npc_mispred", bif.bus_npc_mispred, e.nm);
            chk("bus_npc", bif.bus_npc, e.npc);
        end
        @(posedge clk);
        if (rst) begin
            aq.delete();
            lq.delete();
            m_last = 1'b1;
            m_acnt = 0;
            m_lcnt = 0;
        end else begin
            ar = aq.size() < DEPTH;
            lr = lq.size() < DEPTH;
            if (bif.alu_valid && !ar && m_acnt < CNT_MAX) m_acnt++;
            if (bif.ld_valid && !lr && m_lcnt < CNT_MAX) m_lcnt++;
            if (bif.flush) begin
                aq.delete();
                lq.delete();
            end else begin
                if (aq.size() + lq.size() > 0) begin
                    gl = model_grant_ld();
                    if (gl) void'(lq.pop_front());
                    else    void'(aq.pop_front());
                    m_last = gl;
                end
                if (bif.alu_valid && ar)
                    aq.push_back('{rob: bif.alu_rob_id, data: bif.alu_reg_data,
                                   nv: bif.alu_npc_valid, nm: bif.alu_npc_mispred, npc: bif.alu_npc});
                if (bif.ld_valid && lr)
                    lq.push_back('{rob: bif.ld_rob_id, data: bif.ld_reg_data,
                                   nv: 1'b0, nm: 1'b0, npc: '0});
            end
        end
        #1;
    endtask

    task automatic idle();
        bif.flush           = 1'b0;
        bif.alu_valid       = 1'b0;
        bif.alu_rob_id      = '0;
        bif.alu_reg_data    = '0;
        bif.alu_npc_valid   = 1'b0;
        bif.alu_npc_mispred = 1'b0;
        bif.alu_npc         = '0;
        bif.ld_valid        = 1'b0;
        bif.ld_rob_id       = '0;
        bif.ld_reg_data     = '0;
    endtask

    task automatic set_alu(input logic [ROB_W-1:0] r, input logic [DATA_W-1:0] d,
                           input logic nv, input logic nm, input logic [ADDR_W-1:0] npc);
        bif.alu_valid       = 1'b1;
        bif.alu_rob_id      = r;
        bif.alu_reg_data    = d;
        bif.alu_npc_valid   = nv;
        bif.alu_npc_mispred = nm;
        bif.alu_npc         = npc;
    endtask

    task automatic set_ld(input logic [ROB_W-1:0] r, input logic [DATA_W-1:0] d);
        bif.ld_valid    = 1'b1;
        bif.ld_rob_id   = r;
        bif.ld_reg_data = d;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Reset state, sampled between edges with idle inputs
        #1;
        chk("rst_bus_valid", bif.bus_valid, 1'b0);
        chk("rst_alu_ready", bif.alu_ready, 1'b1);
        chk("rst_ld_ready", bif.ld_ready, 1'b1);
        chk("rst_bus_rob_id", bif.bus_rob_id, 0);

        // 1: single ALU result appears one cycle later, then the bus idles
        set_alu(3, 32'hDEAD, 1'b0, 1'b0, '0);
        step();
        idle();
        #1;
        chk("t1_bus_valid", bif.bus_valid, 1'b1);
        chk("t1_src_ld", bif.bus_src_ld, 1'b0);
        chk("t1_rob_id", bif.bus_rob_id, 3);
        chk("t1_data", bif.bus_reg_data, 32'hDEAD);
        step();
        #1;
        chk("t1_idle_after", bif.bus_valid, 1'b0);
        step();

        // 2: simultaneous ALU/load push after reset
        reset_dut();
        set_alu(1, 32'h11, 1'b0, 1'b0, '0);
        set_ld(2, 32'h22);
        step();
        idle();
        #1;
`ifdef WB_ARB_LD_PRIORITY_EN
        chk("t2_first_rob", bif.bus_rob_id, 2);
`else
        chk("t2_first_rob", bif.bus_rob_id, 1);
`endif
        step();
        #1;
`ifdef WB_ARB_LD_PRIORITY_EN
        chk("t2_second_rob", bif.bus_rob_id, 1);
`else
        chk("t2_second_rob", bif.bus_rob_id, 2);
`endif
        step();
        step();

        // 3: both sources pushing continuously; model tracks order, readiness and stalls
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            if (i < 6) set_alu(ROB_W'(i), $urandom, 1'b0, 1'b0, '0);
            else       bif.alu_valid = 1'b0;
            set_ld(ROB_W'(32 + i), $urandom);
            step();
        end
        idle();
        for (int i = 0; i < 10; i++) step();

        // 4: build up load entries, then flush with a concurrent ALU push
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            set_alu(ROB_W'(i), $urandom, 1'b0, 1'b0, '0);
            set_ld(ROB_W'(16 + i), $urandom);
            step();
        end
        idle();
        bif.flush = 1'b1;
        set_alu(63, 32'hBAD0, 1'b0, 1'b0, '0);
        #1;
        chk("t4_flush_bus_valid", bif.bus_valid, 1'b0);
        step();
        idle();
        #1;
        chk("t4_post_bus_valid", bif.bus_valid, 1'b0);
        chk("t4_post_alu_ready", bif.alu_ready, 1'b1);
        chk("t4_post_ld_ready", bif.ld_ready, 1'b1);
        for (int i = 0; i < 4; i++) step();

        // 5: npc fields ride only on ALU grants
        reset_dut();
        set_alu(5, 32'h55, 1'b1, 1'b1, 32'h80);
        set_ld(6, 32'h66);
        step();
        idle();
        #1;
`ifdef WB_ARB_LD_PRIORITY_EN
        chk("t5_ld_npc_valid", bif.bus_npc_valid, 1'b0);
        chk("t5_ld_npc", bif.bus_npc, 0);
        step();
        #1;
        chk("t5_alu_npc_mispred", bif.bus_npc_mispred, 1'b1);
        chk("t5_alu_npc", bif.bus_npc, 32'h80);
`else
        chk("t5_alu_npc_mispred", bif.bus_npc_mispred, 1'b1);
        chk("t5_alu_npc", bif.bus_npc, 32'h80);
        step();
        #1;
        chk("t5_ld_npc_valid", bif.bus_npc_valid, 1'b0);
        chk("t5_ld_npc", bif.bus_npc, 0);
`endif
        step();

        // 6: long saturation run, then reset in the middle of traffic
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            set_alu(ROB_W'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            set_ld(ROB_W'($urandom), $urandom);
            step();
        end
        #1;
`ifndef WB_ARB_LD_PRIORITY_EN
        chk("t6_ld_stall_sat", bif.ld_stall_cnt, CNT_MAX);
`endif
        chk("t6_alu_stall_sat", bif.alu_stall_cnt, CNT_MAX);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_rst_ld_cnt", bif.ld_stall_cnt, 0);
        chk("t6_rst_alu_cnt", bif.alu_stall_cnt, 0);
        chk("t6_rst_ld_ready", bif.ld_ready, 1'b1);
        chk("t6_rst_bus_valid", bif.bus_valid, 1'b0);
        step();
        idle();
        step();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            bif.flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) != 0)
                set_alu(ROB_W'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            if ($urandom_range(0, 2) != 0)
                set_ld(ROB_W'($urandom), $urandom);
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 12; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
